// File: rtl/mul_pkg.sv
// ============================================================================
// mul_pkg : shared types and defaults for the sequential multiplier
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_N_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/mul_step.sv
// ============================================================================
// mul_step : one combinational radix-2 shift-add iteration
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mul_step
    import mul_pkg::*;
#(
    parameter int N = MUL_N_DEFAULT
) (
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   mcand,
    output logic [2*N-1:0] next_acc
);

    logic [N:0] w_sum;

    // The carry out of the upper-half add becomes the new MSB after the shift.
    always_comb begin
        if (acc[0]) begin
            w_sum = {1'b0, acc[2*N-1:N]} + {1'b0, mcand};
        end else begin
            w_sum = {1'b0, acc[2*N-1:N]};
        end
        next_acc = {w_sum, acc[N-1:1]};
    end

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// seq_multiplier : iterative unsigned N x N -> 2N shift-add multiplier
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seq_multiplier
    import mul_pkg::*;
#(
    parameter int N  = MUL_N_DEFAULT,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] rs1_reg,
    input  logic [N-1:0] rs2_reg,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] rd1_product_lo,
    output logic [N-1:0] rd2_product_hi
);

    mul_state_t     state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   lo_q, lo_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [2*N-1:0] w_next_acc;

    mul_step #(
        .N (N)
    ) u_step (
        .acc      (acc_q),
        .mcand    (mcand_q),
        .next_acc (w_next_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // DONE accepts a new request exactly like IDLE so back-to-back ops lose no cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d = rs1_reg;
                    acc_d   = {{N{1'b0}}, rs2_reg};
                    count_d = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d   = w_next_acc;
                count_d = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    lo_d    = w_next_acc[N-1:0];
                    hi_d    = w_next_acc[2*N-1:N];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign rd1_product_lo = lo_q;
    assign rd2_product_hi = hi_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// ============================================================================
// tb_seq_multiplier : latency/product model bench for seq_multiplier
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_seq_multiplier;

    localparam int N = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] rs1_reg;
    logic [N-1:0] rs2_reg;
    logic         busy;
    logic         done;
    logic [N-1:0] lo;
    logic [N-1:0] hi;

    int n_checks = 0;
    int n_fail   = 0;

    seq_multiplier #(
        .N (N)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .rs1_reg        (rs1_reg),
        .rs2_reg        (rs2_reg),
        .busy           (busy),
        .done           (done),
        .rd1_product_lo (lo),
        .rd2_product_hi (hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a product a*b appears N edges after acceptance.
    int          m_rem;
    logic        m_done;
    logic [31:0] m_prod;
    logic [15:0] m_lo, m_hi;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_lo   <= '0;
            m_hi   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_lo   <= m_prod[15:0];
                    m_hi   <= m_prod[31:16];
                    m_done <= 1'b1;
                end
            end else if (start) begin
                m_rem  <= N;
                m_prod <= {16'd0, rs1_reg} * {16'd0, rs2_reg};
            end
        end
    end

    always @(negedge clk) begin
        check("busy",  32'(busy), 32'(m_rem > 0));
        check("done",  32'(done), 32'(m_done));
        check("lo",    32'(lo),   32'(m_lo));
        check("hi",    32'(hi),   32'(m_hi));
    end

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start   = 1'b1;
        rs1_reg = a;
        rs2_reg = b;
        @(negedge clk);
        start   = 1'b0;
        rs1_reg = 16'($urandom);
        rs2_reg = 16'($urandom);
    endtask

    task automatic wait_done(output int nb);
        int cyc;
        cyc = 0;
        nb  = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy) nb++;
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] elo, input logic [15:0] ehi);
        int nb;
        launch(a, b);
        wait_done(nb);
        check({name, "_lo"}, 32'(lo), 32'(elo));
        check({name, "_hi"}, 32'(hi), 32'(ehi));
        check({name, "_busy_cycles"}, 32'(nb), 32'(N));
        @(negedge clk);
        check({name, "_done_fall"}, 32'(done), 32'd0);
    endtask

    initial begin
        int nb;
        int ndone;
        start   = 1'b0;
        rs1_reg = '0;
        rs2_reg = '0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lo",   32'(lo),   32'd0);
        check("rst_hi",   32'(hi),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic",  16'h0003, 16'h0005, 16'h000F, 16'h0000);
        run_op("max",    16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE);
        run_op("carry",  16'h8000, 16'h0002, 16'h0000, 16'h0001);
        run_op("zero",   16'h1234, 16'h0000, 16'h0000, 16'h0000);
        run_op("ident",  16'h1234, 16'h0001, 16'h1234, 16'h0000);

        // A second request while busy must be ignored.
        launch(16'd7, 16'd9);
        ndone = 0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 5) begin
                start   = 1'b1;
                rs1_reg = 16'hFFFF;
                rs2_reg = 16'hFFFF;
            end else if (i == 6) begin
                start = 1'b0;
            end
            if (done) ndone++;
            @(negedge clk);
        end
        check("busy_ignore_ndone", 32'(ndone), 32'd1);
        check("busy_ignore_lo",    32'(lo),    32'h003F);
        check("busy_ignore_hi",    32'(hi),    32'h0000);

        // Reset in the middle of an operation discards it immediately.
        launch(16'h00FF, 16'h0100);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_lo",   32'(lo),   32'd0);
        check("midrst_hi",   32'(hi),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        run_op("after_rst", 16'h0002, 16'h0002, 16'h0004, 16'h0000);

        // Back-to-back: new request issued during the DONE cycle.
        launch(16'h0003, 16'h0005);
        wait_done(nb);
        check("b2b_first_lo", 32'(lo), 32'h000F);
        start   = 1'b1;
        rs1_reg = 16'h0010;
        rs2_reg = 16'h0010;
        @(negedge clk);
        start = 1'b0;
        check("b2b_rerun_busy", 32'(busy), 32'd1);
        check("b2b_hold_lo",    32'(lo),   32'h000F);
        wait_done(nb);
        check("b2b_second_lo",    32'(lo), 32'h0100);
        check("b2b_second_hi",    32'(hi), 32'h0000);
        check("b2b_busy_cycles",  32'(nb), 32'(N));
        @(negedge clk);
        check("b2b_done_fall", 32'(done), 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
